// File: rtl/writeback_unit.sv
// Register-file write-port master: merges EX results and in-order load responses
// into one registered write per cycle, and tracks outstanding load destinations.
module writeback_unit #(
    parameter int XLEN         = 32,
    parameter int REG_NUM_SIZE = 5,
    parameter int QDEPTH       = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ex_valid,
    input  logic [REG_NUM_SIZE-1:0]      ex_rd,
    input  logic [XLEN-1:0]              ex_data,
    output logic                         ex_ready,
    input  logic                         ld_issue,
    input  logic [REG_NUM_SIZE-1:0]      ld_rd,
    output logic                         ld_full,
    input  logic                         ld_resp_valid,
    input  logic [XLEN-1:0]              ld_resp_data,
    output logic                         wb_we,
    output logic [REG_NUM_SIZE-1:0]      wb_addr,
    output logic [XLEN-1:0]              wb_data,
    output logic [(1<<REG_NUM_SIZE)-1:0] pending,
    output logic                         err
);
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 1 << REG_NUM_SIZE;

    logic [REG_NUM_SIZE-1:0] tag_mem [QDEPTH];
    logic [PTR_W-1:0]        rd_ptr_reg, wr_ptr_reg;
    logic [CNT_W-1:0]        count_reg;
    logic [CNT_W-1:0]        count_next;
    logic                    err_reg;
    logic                    wb_we_reg;
    logic [REG_NUM_SIZE-1:0] wb_addr_reg;
    logic [XLEN-1:0]         wb_data_reg;

    logic                    fifo_empty;
    logic                    push;
    logic                    pop;
    logic                    sel_valid;
    logic [REG_NUM_SIZE-1:0] sel_rd;
    logic [XLEN-1:0]         sel_data;
    logic                    wb_we_next;

    // Full comes from the registered count only, so a same-cycle pop never frees a slot early.
    assign fifo_empty = (count_reg == '0);
    assign ld_full    = (count_reg == CNT_W'(QDEPTH));
    assign push       = ld_issue && !ld_full;
    assign pop        = ld_resp_valid && !fifo_empty;
    assign ex_ready   = !pop;

    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        if (pop) begin
            sel_valid = 1'b1;
            sel_rd    = tag_mem[rd_ptr_reg];
            sel_data  = ld_resp_data;
        end else if (ex_valid) begin
            sel_valid = 1'b1;
            sel_rd    = ex_rd;
            sel_data  = ex_data;
        end
        wb_we_next = sel_valid && (sel_rd != '0);
        count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_reg] <= ld_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg  <= '0;
            wr_ptr_reg  <= '0;
            count_reg   <= '0;
            err_reg     <= 1'b0;
            wb_we_reg   <= 1'b0;
            wb_addr_reg <= '0;
            wb_data_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= PTR_W'(wr_ptr_reg + 1'b1);
            end
            if (pop) begin
                rd_ptr_reg <= PTR_W'(rd_ptr_reg + 1'b1);
            end
            count_reg <= count_next;
            if (ld_resp_valid && fifo_empty) begin
                err_reg <= 1'b1;
            end
            wb_we_reg <= wb_we_next;
            if (wb_we_next) begin
                wb_addr_reg <= sel_rd;
                wb_data_reg <= sel_data;
            end
        end
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    logic [NREG-1:0] entry_dec [QDEPTH];

    generate
        for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_entry
            logic [PTR_W-1:0] offset;
            logic             live;
            assign offset        = PTR_W'(gi) - rd_ptr_reg;
            assign live          = ({1'b0, offset} < count_reg);
            assign entry_dec[gi] = live ? (NREG'(1) << tag_mem[gi]) : '0;
        end
    endgenerate

    always_comb begin
        pending = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            pending = pending | entry_dec[i];
        end
        pending[0] = 1'b0;
    end

    assign wb_we   = wb_we_reg;
    assign wb_addr = wb_addr_reg;
    assign wb_data = wb_data_reg;
    assign err     = err_reg;
endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: a queue-based model checked every cycle,
// plus literal expectations for each scenario.
module tb_writeback_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic [31:0] ex_data;
    logic        ex_ready;
    logic        ld_issue;
    logic [4:0]  ld_rd;
    logic        ld_full;
    logic        ld_resp_valid;
    logic [31:0] ld_resp_data;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] pending;
    logic        err;

    writeback_unit #(.XLEN(32), .REG_NUM_SIZE(5), .QDEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data), .ex_ready(ex_ready),
        .ld_issue(ld_issue), .ld_rd(ld_rd), .ld_full(ld_full),
        .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .pending(pending), .err(err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model state: outstanding load tags in issue order, expected write port, sticky error.
    int          tagq[$];
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_err;
    bit          model_ok = 0;

    logic [31:0] rf [32];
    int          log_addr[$];
    logic [31:0] log_data[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_pend;
        int          rd;
        logic [31:0] d;
        bit          sel;
        bit          was_full;
        bit          was_empty;
        forever begin
            @(posedge clk);
            if (rst) begin
                tagq.delete();
                m_we = 0; m_addr = 0; m_data = 0; m_err = 0;
                model_ok = 1;
            end else begin
                was_full  = (tagq.size() == 4);
                was_empty = (tagq.size() == 0);
                sel = 0; rd = 0; d = 0;
                if (ld_resp_valid && !was_empty) begin
                    rd = tagq.pop_front(); d = ld_resp_data; sel = 1;
                end else if (ex_valid) begin
                    rd = int'(ex_rd); d = ex_data; sel = 1;
                end
                if (ld_resp_valid && was_empty) m_err = 1;
                if (ld_issue && !was_full) tagq.push_back(int'(ld_rd));
                m_we = sel && (rd != 0);
                if (m_we) begin
                    m_addr = 5'(rd);
                    m_data = d;
                end
            end
            @(negedge clk);
            if (model_ok) begin
                exp_pend = '0;
                foreach (tagq[k]) exp_pend[tagq[k]] = 1'b1;
                exp_pend[0] = 1'b0;
                check("wb_we", 64'(wb_we), 64'(m_we));
                check("wb_addr", 64'(wb_addr), 64'(m_addr));
                check("wb_data", 64'(wb_data), 64'(m_data));
                check("pending", 64'(pending), 64'(exp_pend));
                check("ld_full", 64'(ld_full), 64'(tagq.size() == 4));
                check("err", 64'(err), 64'(m_err));
                check("ex_ready", 64'(ex_ready), 64'(!(ld_resp_valid && tagq.size() != 0)));
            end
            if (wb_we === 1'b1) begin
                rf[wb_addr] = wb_data;
                log_addr.push_back(int'(wb_addr));
                log_data.push_back(wb_data);
                $display("[TB] wb x%0d <= 0x%08h", wb_addr, wb_data);
            end
        end
    end

    initial begin
        rst = 1;
        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            ex_valid = 1'($urandom); ex_rd = 5'($urandom); ex_data = $urandom;
            ld_issue = 1'($urandom); ld_rd = 5'($urandom);
            ld_resp_valid = 1'($urandom); ld_resp_data = $urandom;
            if (i == 0) #1; else step();
            if (i == 0) step();
        end
        rst = 0; ex_valid = 0; ex_rd = 0; ex_data = 0;
        ld_issue = 0; ld_rd = 0; ld_resp_valid = 0; ld_resp_data = 0;
        #1;
        check("rst_wb_we", 64'(wb_we), 0);
        check("rst_wb_addr", 64'(wb_addr), 0);
        check("rst_wb_data", 64'(wb_data), 0);
        check("rst_pending", 64'(pending), 0);
        check("rst_ld_full", 64'(ld_full), 0);
        check("rst_err", 64'(err), 0);
        step();

        // EX path
        ex_valid = 1; ex_rd = 5; ex_data = 32'hDEADBEEF;
        #1 check("ex_ready_ex", 64'(ex_ready), 1);
        step();
        ex_valid = 0;
        check("ex_wb_we", 64'(wb_we), 1);
        check("ex_wb_addr", 64'(wb_addr), 5);
        check("ex_wb_data", 64'(wb_data), 64'h00000000DEADBEEF);
        step();
        check("rf_x5", 64'(rf[5]), 64'h00000000DEADBEEF);
        ex_valid = 1; ex_rd = 0; ex_data = 32'h12345678;
        step();
        ex_valid = 0;
        check("ex_x0_we", 64'(wb_we), 0);
        check("ex_x0_hold", 64'(wb_data), 64'h00000000DEADBEEF);
        step();

        // Load ordering and scoreboard
        log_addr.delete(); log_data.delete();
        ld_issue = 1; ld_rd = 3; step();
        ld_rd = 7; step();
        ld_rd = 3; step();
        ld_issue = 0;
        check("pend_3loads", 64'(pending), 64'h88);
        ld_resp_valid = 1; ld_resp_data = 32'hA; step();
        check("pend_after_A", 64'(pending), 64'h88);
        ld_resp_data = 32'hB; step();
        check("pend_after_B", 64'(pending), 64'h08);
        ld_resp_data = 32'hC; step();
        ld_resp_valid = 0;
        check("pend_after_C", 64'(pending), 0);
        step();
        check("ld_log_size", 64'(log_addr.size()), 3);
        check("ld_w0_addr", 64'(log_addr[0]), 3);
        check("ld_w0_data", 64'(log_data[0]), 64'hA);
        check("ld_w1_addr", 64'(log_addr[1]), 7);
        check("ld_w1_data", 64'(log_data[1]), 64'hB);
        check("ld_w2_addr", 64'(log_addr[2]), 3);
        check("ld_w2_data", 64'(log_data[2]), 64'hC);

        // EX/load conflict
        log_addr.delete(); log_data.delete();
        ld_issue = 1; ld_rd = 4; step();
        ld_issue = 0;
        ex_valid = 1; ex_rd = 9; ex_data = 32'h11;
        ld_resp_valid = 1; ld_resp_data = 32'h22;
        #1 check("conflict_ex_ready0", 64'(ex_ready), 0);
        step();
        ld_resp_valid = 0;
        #1 check("conflict_ex_ready1", 64'(ex_ready), 1);
        step();
        ex_valid = 0;
        step();
        check("cf_log_size", 64'(log_addr.size()), 2);
        check("cf_w0_addr", 64'(log_addr[0]), 4);
        check("cf_w0_data", 64'(log_data[0]), 64'h22);
        check("cf_w1_addr", 64'(log_addr[1]), 9);
        check("cf_w1_data", 64'(log_data[1]), 64'h11);

        // Full and pointer wrap
        log_addr.delete(); log_data.delete();
        for (int i = 0; i < 4; i++) begin
            ld_issue = 1; ld_rd = 5'(10 + i); step();
        end
        check("full_after4", 64'(ld_full), 1);
        ld_rd = 14; step();
        ld_issue = 0;
        check("fifth_ignored", 64'(pending), 64'h3C00);
        for (int i = 0; i < 10; i++) begin
            ld_issue = 1; ld_rd = 5'(16 + i);
            ld_resp_valid = 1; ld_resp_data = 32'h100 + 32'(i);
            step();
            if (i == 0) check("full_drop_after_pop", 64'(ld_full), 0);
        end
        ld_issue = 0;
        for (int j = 0; j < 3; j++) begin
            ld_resp_data = 32'h200 + 32'(j); step();
        end
        ld_resp_valid = 0;
        step();
        check("wrap_pend_empty", 64'(pending), 0);
        check("wrap_log_size", 64'(log_addr.size()), 13);
        check("wrap_w0_addr", 64'(log_addr[0]), 10);
        check("wrap_w0_data", 64'(log_data[0]), 64'h100);
        check("wrap_w4_addr", 64'(log_addr[4]), 17);
        check("wrap_w4_data", 64'(log_data[4]), 64'h104);
        check("wrap_w12_addr", 64'(log_addr[12]), 25);
        check("wrap_w12_data", 64'(log_data[12]), 64'h202);

        // Protocol error
        log_addr.delete(); log_data.delete();
        ld_resp_valid = 1; ld_resp_data = 32'hBAD; step();
        ld_resp_valid = 0;
        check("err_set", 64'(err), 1);
        check("err_no_we", 64'(wb_we), 0);
        step(); step();
        check("err_sticky", 64'(err), 1);
        check("err_no_log", 64'(log_addr.size()), 0);
        ld_issue = 1; ld_rd = 6; ld_resp_valid = 1; ld_resp_data = 32'h55; step();
        ld_issue = 0; ld_resp_valid = 0;
        check("empty_both_push", 64'(pending), 64'h40);
        ld_resp_valid = 1; ld_resp_data = 32'h66; step();
        ld_resp_valid = 0;
        check("drain_x6_we", 64'(wb_we), 1);
        check("drain_x6_addr", 64'(wb_addr), 6);
        ld_issue = 1; ld_rd = 8; step();
        ld_issue = 0;
        check("midop_pend", 64'(pending), 64'h100);
        rst = 1; step();
        rst = 0;
        check("rst2_pend", 64'(pending), 0);
        check("rst2_err", 64'(err), 0);
        check("rst2_we", 64'(wb_we), 0);
        ld_resp_valid = 1; ld_resp_data = 32'h77; step();
        ld_resp_valid = 0;
        check("post_rst_err", 64'(err), 1);
        step(); step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
